// File: rtl/edge_event_arbiter_pkg.sv
// Shared constants, width helpers and slot state for the edge event arbiter.
package edge_evt_pkg;

  localparam int NUM_SRC_DEF = 32;

  function automatic int id_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } slot_state_e;

endpackage

// File: rtl/edge_event_arbiter_rr_pick.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping.
module rr_pick
  import edge_evt_pkg::*;
#(
  parameter int NUM_SRC = NUM_SRC_DEF,
  parameter int ID_W    = id_w(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic               gnt_valid,
  output logic [ID_W-1:0]    gnt_id
);

  int w_idx;

  // Walk offsets from farthest to nearest so the nearest hit is the last write.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_id    = '0;
    w_idx     = 0;
    for (int k = NUM_SRC - 1; k >= 0; k--) begin
      w_idx = int'(ptr) + k;
      if (w_idx >= NUM_SRC) w_idx = w_idx - NUM_SRC;
      if (req[w_idx]) begin
        gnt_valid = 1'b1;
        gnt_id    = ID_W'(w_idx);
      end
    end
  end

endmodule

// File: rtl/edge_event_arbiter.sv
// Turns new rising bits of a sticky edge vector into round-robin serialised
// event IDs on a valid/ready stream, flagging re-arrivals as sticky overflow.
module edge_event_arbiter
  import edge_evt_pkg::*;
#(
  parameter int NUM_SRC = NUM_SRC_DEF,
  parameter int ID_W    = id_w(NUM_SRC),
  parameter int CNT_W   = cnt_w(NUM_SRC)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_SRC-1:0] edge_i,
  output logic               evt_valid_o,
  output logic [ID_W-1:0]    evt_id_o,
  input  logic               evt_ready_i,
  output logic [NUM_SRC-1:0] overflow_o,
  input  logic               clr_ovf_i,
  output logic [CNT_W-1:0]   pending_cnt_o
);

  logic [NUM_SRC-1:0] r_edge_q, r_pending, r_ovf;
  logic [ID_W-1:0]    r_ptr, r_id;
  logic [CNT_W-1:0]   r_cnt;
  slot_state_e        r_state;

  logic [NUM_SRC-1:0] w_rise, w_clr, w_pend_nxt, w_ovf_set;
  logic               w_gnt_valid, w_hs, w_load;
  logic [ID_W-1:0]    w_gnt_id, w_ptr_nxt;
  logic [CNT_W-1:0]   w_cnt_nxt;

  rr_pick #(.NUM_SRC(NUM_SRC), .ID_W(ID_W)) u_pick (
    .req       (r_pending),
    .ptr       (r_ptr),
    .gnt_valid (w_gnt_valid),
    .gnt_id    (w_gnt_id)
  );

  assign w_rise    = edge_i & ~r_edge_q;
  assign w_hs      = (r_state == FULL) & evt_ready_i;
  assign w_load    = ((r_state == EMPTY) | w_hs) & w_gnt_valid;
  // A source living only in the output slot is not pending, so its re-rise is legal.
  assign w_ovf_set = w_rise & r_pending;
  assign w_ptr_nxt = (w_gnt_id == ID_W'(NUM_SRC - 1)) ? '0 : w_gnt_id + ID_W'(1);

  always_comb begin
    w_clr = '0;
    if (w_load) w_clr[w_gnt_id] = 1'b1;
  end

  // A rise coinciding with the load of the same source keeps the new event.
  assign w_pend_nxt = (r_pending & ~w_clr) | w_rise;

  always_comb begin
    w_cnt_nxt = '0;
    for (int i = 0; i < NUM_SRC; i++) w_cnt_nxt = w_cnt_nxt + CNT_W'(w_pend_nxt[i]);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_edge_q  <= '0;
      r_pending <= '0;
      r_ovf     <= '0;
      r_ptr     <= '0;
      r_id      <= '0;
      r_cnt     <= '0;
      r_state   <= EMPTY;
    end else begin
      r_edge_q  <= edge_i;
      r_pending <= w_pend_nxt;
      r_cnt     <= w_cnt_nxt;
      r_ovf     <= (clr_ovf_i ? '0 : r_ovf) | w_ovf_set;
      if (w_load) begin
        r_state <= FULL;
        r_id    <= w_gnt_id;
        r_ptr   <= w_ptr_nxt;
      end else if (w_hs) begin
        r_state <= EMPTY;
      end
    end
  end

  assign evt_valid_o   = (r_state == FULL);
  assign evt_id_o      = r_id;
  assign overflow_o    = r_ovf;
  assign pending_cnt_o = r_cnt;

endmodule

// File: doc/edge_event_arbiter.md
# edge_event_arbiter

Downstream consumer of the 32-bit sticky edge-capture vector. Each new 0→1 transition of an input bit is turned into a pending event. Pending events are serialised one at a time as 5-bit source IDs on a valid/ready stream, using round-robin priority. Re-arrival of an event that is still pending sets a sticky per-source overflow flag, so lost events are never silent.

## Interface
- NUM_SRC, 32, number of event sources (width of edge_i); 2..32
- ID_W, $clog2(NUM_SRC), width of evt_id_o
- CNT_W, $clog2(NUM_SRC+1), width of pending_cnt_o

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- edge_i  in  NUM_SRC  sticky edge vector from the capture stage
- evt_valid_o  out  1  event ID available
- evt_id_o  out  ID_W  source index of the presented event
- evt_ready_i  in  1  sink accepts the event
- overflow_o  out  NUM_SRC  sticky: event arrived while the same source was already pending
- clr_ovf_i  in  1  synchronous clear of all overflow_o bits
- pending_cnt_o  out  CNT_W  popcount of the pending register (excludes the event in the output slot)

## Operation
- edge_q registers edge_i. rise = edge_i & ~edge_q.
- pending[i]:
  - set when rise[i]=1;
  - cleared when i is loaded into the output slot;
  - if set and clear coincide, set wins (a new event is kept).
- Overflow: rise[i] while pending[i]=1 sets overflow[i].
  - A rise while i sits only in the output slot is a legal new event, not an overflow.
  - If clr_ovf_i and an overflow set occur in the same cycle, set wins.
- Output slot states:
  - EMPTY: evt_valid_o=0. If pending≠0, load the winner → FULL.
  - FULL: evt_valid_o=1 and evt_id_o stable until handshake (evt_valid_o & evt_ready_i).
    - On handshake with pending≠0: load the next winner in the same cycle, stay FULL.
    - On handshake with pending=0: → EMPTY.
- Round robin:
  - Pointer ptr (ID_W bits, reset 0).
  - Winner = first set pending bit searching ptr, ptr+1, …, NUM_SRC-1, 0, …, ptr-1.
  - On load, ptr = winner+1, wrapping to 0 after NUM_SRC-1.
- pending_cnt_o is registered and reflects the pending register after each edge.
- Reset values:
  - All outputs 0; state EMPTY.
  - pending, overflow, edge_q and ptr all 0.
  - Because edge_q resets to 0, an edge_i bit that is high on the first post-reset edge is treated as a rise.

## Timing
- Source i rises (edge_i[i] 0→1 sampled at edge k): pending[i]=1 and pending_cnt_o updated after edge k.
- With the slot EMPTY, evt_valid_o=1 with evt_id_o=i after edge k+1. Minimum latency is 2 cycles.
- Throughput: 1 event per cycle while evt_ready_i is held high and pending≠0.
- Backpressure: evt_valid_o must not drop and evt_id_o must not change without a handshake.
- A reset asserted mid-operation clears everything immediately (async). An in-flight event in the output slot is discarded.
- edge_i falling has no effect. The sticky upstream source must be cleared upstream before that bit can generate a new event.

## Structure
- Package edge_evt_pkg:
  - NUM_SRC default constant;
  - ID_W/CNT_W derivation functions;
  - slot state enum {EMPTY, FULL}.
- Sub-module rr_pick:
  - combinational rotate-find-first;
  - inputs: req[NUM_SRC], ptr[ID_W];
  - outputs: gnt_valid, gnt_id[ID_W].
- Top level holds edge_q, pending, overflow, ptr, the output slot and the popcount register.

## Test plan
- Single event: edge_i[5] 0→1 at edge 1, evt_ready_i=1 → evt_valid_o=1, evt_id_o=5 after edge 2; valid low after edge 3; pending_cnt_o 1→0.
- Simultaneous sources:
  - Stimulus: edge_i bits 3, 7, 31 rise together; ptr=0; ready held high.
  - Required: IDs 3, 7, 31 on consecutive cycles.
  - Then bits 0 and 4 rise: 0 is presented before 4 (pointer wrapped to 0 after 31).
- Backpressure:
  - Stimulus: bits 1 and 2 pending; evt_ready_i=0 for 5 cycles.
  - Required: evt_id_o=1 held stable with valid=1; pending_cnt_o=1.
  - Then ready=1 → ID 2 on the next cycle.
- Overflow:
  - Stimulus: ready=0 with pending[9]=1 (another ID in the slot); drop edge_i[9] to 0, then raise it again.
  - Required: overflow_o[9]=1, pending_cnt_o unchanged.
  - Then clr_ovf_i for 1 cycle → overflow_o=0.
- Re-arm while in slot: ID 6 in slot (not pending), rise on bit 6 → no overflow; after accept, ID 6 is presented again.
- Reset mid-operation:
  - Stimulus: 4 pending plus valid high; pulse reset between clock edges.
  - Required: evt_valid_o, overflow_o and pending_cnt_o all 0 immediately; edge_i held high on the first post-reset edge yields new events.
